// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
//  Module      : memory_controller
//  Description : Sequences single-word read/write accesses onto a bank of
//                DATA_W one-bit, 16-cell memory slices. Each access runs
//                SETUP -> STROBE (STROBE_CYC cycles) -> HOLD, and a read
//                then waits in RESP until the consumer takes the data.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_controller #(
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [3:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // response channel (reads only)
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    // slice interface
    output logic              mem_we,
    output logic              mem_re,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_dout,
    output logic              mem_doe,
    input  logic [DATA_W-1:0] mem_din
);

    // The strobe counter is only 4 bits wide, so widths outside 1..15
    // cannot be represented and must stop the build.
    generate
        if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe_cyc
            $error("memory_controller: STROBE_CYC must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] STROBE_INIT = 4'(STROBE_CYC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t     state;
    logic       wr_q;      // direction of the access in flight
    logic [3:0] cnt;       // remaining STROBE cycles, including the current one

    // The address and write data of the accepted request are held directly
    // in the mem_sel / mem_dout output registers, which keeps them stable
    // from SETUP through HOLD without a second copy.

    // Access sequencer: state, strobe counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_sel   <= 4'd0;
            mem_dout  <= '0;
            mem_doe   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_doe  <= 1'b0;
                    mem_dout <= '0;
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        mem_sel   <= req_addr;
                        mem_doe   <= req_write;
                        mem_dout  <= req_write ? req_wdata : '0;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    // Exactly one strobe rises; the direction is mutually exclusive.
                    mem_we <= wr_q;
                    mem_re <= ~wr_q;
                    cnt    <= STROBE_INIT;
                    state  <= STROBE;
                end

                STROBE: begin
                    if (cnt == 4'd1) begin
                        // Edge ending the last strobe cycle: sample the slices
                        // while mem_re is still asserted.
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        cnt    <= 4'd0;
                        if (!wr_q) begin
                            rsp_rdata <= mem_din;
                        end
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                HOLD: begin
                    if (wr_q) begin
                        // Writes complete silently and release the data lines.
                        mem_doe   <= 1'b0;
                        mem_dout  <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    // rsp_rdata is left untouched so it stays stable while waiting.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    mem_we    <= 1'b0;
                    mem_re    <= 1'b0;
                    mem_doe   <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_controller
//  Description : Directed self-checking bench for memory_controller with a
//                16-word slice model; two extra instances exercise the
//                shortest and longest strobe widths.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_controller;

    localparam int S = 2;   // strobe width of the main instance

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] mem_sel;
    logic [7:0] mem_dout;
    logic       mem_doe;
    logic [7:0] mem_din;

    int checks = 0;
    int failures = 0;

    logic [7:0] model [16];

    always #5 clk = ~clk;

    memory_controller #(.DATA_W(8), .STROBE_CYC(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_sel   (mem_sel),
        .mem_dout  (mem_dout),
        .mem_doe   (mem_doe),
        .mem_din   (mem_din)
    );

    // Slice model: store on a strobed, driven write; sense only while read-strobed.
    always @(posedge clk) begin
        if (mem_we && mem_doe) model[mem_sel] <= mem_dout;
    end
    assign mem_din = mem_re ? model[mem_sel] : 8'h00;

    // Extra instances with strobe widths 1 and 15; slices return 0xC3.
    logic       aux_valid [2];
    logic       aux_ready [2];
    logic       aux_rv    [2];
    logic [7:0] aux_rd    [2];
    logic       aux_we    [2];
    logic       aux_re    [2];
    logic [3:0] aux_sel   [2];
    logic [7:0] aux_dout  [2];
    logic       aux_doe   [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_aux
            memory_controller #(.DATA_W(8), .STROBE_CYC(g == 0 ? 1 : 15)) u_aux (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (aux_valid[g]),
                .req_ready (aux_ready[g]),
                .req_write (1'b0),
                .req_addr  (4'd2),
                .req_wdata (8'h00),
                .rsp_valid (aux_rv[g]),
                .rsp_ready (rsp_ready),
                .rsp_rdata (aux_rd[g]),
                .mem_we    (aux_we[g]),
                .mem_re    (aux_re[g]),
                .mem_sel   (aux_sel[g]),
                .mem_dout  (aux_dout[g]),
                .mem_doe   (aux_doe[g]),
                .mem_din   (aux_re[g] ? 8'hC3 : 8'h00)
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes must never overlap on the main instance.
    always @(negedge clk) begin
        if (rst_n) chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
    end

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        chk("wr_ready_before", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("wr_setup_ready", req_ready, 0);
        chk("wr_setup_sel", mem_sel, addr);
        chk("wr_setup_dout", mem_dout, data);
        chk("wr_setup_doe", mem_doe, 1);
        chk("wr_setup_we", mem_we, 0);
        for (int i = 0; i < S; i++) begin
            tick();
            chk("wr_strobe_we", mem_we, 1);
            chk("wr_strobe_re", mem_re, 0);
            chk("wr_strobe_sel", mem_sel, addr);
            chk("wr_strobe_dout", mem_dout, data);
            chk("wr_strobe_doe", mem_doe, 1);
        end
        tick();
        chk("wr_hold_we", mem_we, 0);
        chk("wr_hold_sel", mem_sel, addr);
        chk("wr_hold_dout", mem_dout, data);
        chk("wr_hold_doe", mem_doe, 1);
        chk("wr_hold_ready", req_ready, 0);
        tick();
        chk("wr_done_ready", req_ready, 1);
        chk("wr_done_doe", mem_doe, 0);
        chk("wr_done_dout", mem_dout, 0);
        chk("wr_done_sel", mem_sel, addr);
        chk("wr_done_rsp", rsp_valid, 0);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [7:0] exp, input int wait_cyc);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = 8'hFF;
        chk("rd_ready_before", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("rd_setup_sel", mem_sel, addr);
        chk("rd_setup_doe", mem_doe, 0);
        chk("rd_setup_re", mem_re, 0);
        chk("rd_setup_dout", mem_dout, 0);
        for (int i = 0; i < S; i++) begin
            tick();
            chk("rd_strobe_re", mem_re, 1);
            chk("rd_strobe_we", mem_we, 0);
            chk("rd_strobe_doe", mem_doe, 0);
            chk("rd_strobe_sel", mem_sel, addr);
            chk("rd_strobe_rsp", rsp_valid, 0);
        end
        tick();
        chk("rd_hold_re", mem_re, 0);
        chk("rd_hold_rsp", rsp_valid, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_rdata, exp);
        chk("rd_rsp_ready", req_ready, 0);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk("rd_wait_valid", rsp_valid, 1);
            chk("rd_wait_data", rsp_rdata, exp);
            chk("rd_wait_ready", req_ready, 0);
            chk("rd_wait_strobes", {mem_we, mem_re}, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_valid", rsp_valid, 0);
        chk("rd_done_ready", req_ready, 1);
    endtask

    // Watchdog: the directed sequence is a few thousand cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence.
    initial begin
        int width;
        int lat;
        aux_valid[0] = 1'b0;
        aux_valid[1] = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_strobes", {mem_we, mem_re}, 0);
        chk("rst_sel", mem_sel, 0);
        chk("rst_dout", mem_dout, 0);
        chk("rst_doe", mem_doe, 0);
        rst_n = 1'b1;

        // First accept on the very next edge after release.
        do_write(4'd5, 8'hA5);
        do_write(4'd15, 8'h3C);
        do_read(4'd15, 8'h3C, 0);
        do_read(4'd5, 8'hA5, 10);

        // Back-to-back: second request held valid through the first write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'h77;
        tick();
        req_addr = 4'd4; req_wdata = 8'h88;
        repeat (S + 1) tick();
        chk("b2b_hold_ready", req_ready, 0);
        chk("b2b_hold_sel", mem_sel, 3);
        chk("b2b_hold_dout", mem_dout, 8'h77);
        tick();
        chk("b2b_idle_ready", req_ready, 1);
        chk("b2b_idle_doe", mem_doe, 0);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_sel", mem_sel, 4);
        chk("b2b_second_dout", mem_dout, 8'h88);
        chk("b2b_second_doe", mem_doe, 1);
        chk("b2b_second_ready", req_ready, 0);
        repeat (S + 2) tick();
        chk("b2b_second_done", req_ready, 1);
        do_read(4'd3, 8'h77, 0);
        do_read(4'd4, 8'h88, 0);

        // Reset asserted in the middle of a write strobe.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = 8'h42;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_rst_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_re", mem_re, 0);
        chk("mid_rst_sel", mem_sel, 0);
        chk("mid_rst_dout", mem_dout, 0);
        chk("mid_rst_doe", mem_doe, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
            chk("post_rst_strobes", {mem_we, mem_re}, 0);
        end

        // Full sweep: every cell written with addr*0x11, then read back.
        for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a * 17));
        for (int a = 0; a < 16; a++) do_read(4'(a), 8'(a * 17), 0);

        // Strobe width and read latency of the 1- and 15-cycle instances.
        for (int k = 0; k < 2; k++) begin
            width = 0;
            lat = 0;
            chk("aux_ready_before", aux_ready[k], 1);
            aux_valid[k] = 1'b1;
            tick();
            aux_valid[k] = 1'b0;
            for (int n = 1; n <= 40 && lat == 0; n++) begin
                if (aux_re[k]) width++;
                chk("aux_no_we", aux_we[k], 0);
                if (aux_rv[k]) lat = n;
                else tick();
            end
            chk("aux_strobe_width", width, (k == 0) ? 1 : 15);
            chk("aux_read_latency", lat, (k == 0) ? 4 : 18);
            chk("aux_rdata", aux_rd[k], 8'hC3);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("aux_rsp_drop", aux_rv[k], 0);
            chk("aux_ready_after", aux_ready[k], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
